// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser with a first-word-fall-through event FIFO.
// Optional `MIDI_CHAN_FILTER_EN adds a chan_sel port; only matching channels are queued.
module midi_msg_parser #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
`ifdef MIDI_CHAN_FILTER_EN
  input  logic [3:0] chan_sel,
`endif
  output logic       ev_valid,
  output logic [1:0] ev_type,
  output logic [3:0] ev_chan,
  output logic [6:0] ev_note,
  output logic [6:0] ev_vel,
  input  logic       ev_rd,
  output logic       fifo_full,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  state_t     state;
  logic [7:0] status;
  logic [6:0] d1;

  logic        is_rt;
  logic        is_data;
  logic        msg_done;
  logic        ev_keep;
  logic [1:0]  ev_kind;
  logic        chan_ok;
  logic        push;
  logic [19:0] entry;

  assign is_rt    = (byte_in >= 8'hF8);
  assign is_data  = ~byte_in[7];
  assign msg_done = byte_valid && is_data && (state == WAIT_D2);

  // Velocity-zero note-on is reported as note-off.
  always_comb begin
    ev_keep = 1'b0;
    ev_kind = 2'b00;
    case (status[7:4])
      4'h8: begin ev_keep = 1'b1; ev_kind = 2'b00; end
      4'h9: begin ev_keep = 1'b1; ev_kind = (byte_in[6:0] != 7'd0) ? 2'b01 : 2'b00; end
      4'hB: begin ev_keep = 1'b1; ev_kind = 2'b10; end
      default: begin ev_keep = 1'b0; ev_kind = 2'b00; end
    endcase
  end

`ifdef MIDI_CHAN_FILTER_EN
  assign chan_ok = (status[3:0] == chan_sel);
`else
  assign chan_ok = 1'b1;
`endif

  assign push  = msg_done && ev_keep && chan_ok;
  assign entry = {ev_kind, status[3:0], d1, byte_in[6:0]};

  // Parser FSM; real-time bytes leave everything untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      status <= 8'h00;
    end else if (byte_valid && !is_rt) begin
      if (!is_data) begin
        if (byte_in < 8'hF0) begin
          status <= byte_in;
          state  <= WAIT_D1;
        end else if (byte_in == 8'hF0) begin
          status <= 8'h00;
          state  <= SYSEX;
        end else begin
          status <= 8'h00;
          state  <= IDLE;
        end
      end else begin
        case (state)
          WAIT_D1: if (status[7:5] != 3'b110) state <= WAIT_D2;
          WAIT_D2: state <= WAIT_D1;
          default: state <= state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid && is_data && (state == WAIT_D1)) d1 <= byte_in[6:0];
  end

  logic [19:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               pop;
  logic               do_push;
  logic               drop;
  logic [19:0]        head;

  assign full    = (count == DEPTH_C);
  assign pop     = ev_rd && (count != '0);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  // Fields are forced to zero while empty so the head slot's stale contents never show.
  assign head      = mem[rd_ptr];
  assign ev_valid  = (count != '0);
  assign ev_type   = ev_valid ? head[19:18] : 2'b00;
  assign ev_chan   = ev_valid ? head[17:14] : 4'h0;
  assign ev_note   = ev_valid ? head[13:7]  : 7'h00;
  assign ev_vel    = ev_valid ? head[6:0]   : 7'h00;
  assign fifo_full = full;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: vector table, directed corner sequences,
// and randomized byte streams compared against a message-level reference model.
module tb_midi_msg_parser;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       ev_rd = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_type;
  logic [3:0] ev_chan;
  logic [6:0] ev_note;
  logic [6:0] ev_vel;
  logic       fifo_full;
  logic       overflow;
`ifdef MIDI_CHAN_FILTER_EN
  logic [3:0] chan_sel = 4'd0;
`endif

  midi_msg_parser #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
`ifdef MIDI_CHAN_FILTER_EN
    .chan_sel(chan_sel),
`endif
    .ev_valid(ev_valid), .ev_type(ev_type), .ev_chan(ev_chan), .ev_note(ev_note),
    .ev_vel(ev_vel), .ev_rd(ev_rd), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: message-level view of the MIDI stream plus an event queue.
  typedef struct { int t; int c; int n; int v; } ev_t;
  ev_t q[$];
  int  rs = -1;
  int  have = 0;
  int  d1m = 0;
  bit  ovf_m = 1'b0;

  task automatic model_reset();
    rs = -1; have = 0; ovf_m = 1'b0;
    q.delete();
  endtask

  task automatic model_edge(input int b, input bit v, input bit rd);
    ev_t e;
    bit got;
    int hi;
    got = 1'b0;
    e = '{0, 0, 0, 0};
    if (v) begin
      if (b >= 'hF8) begin
      end else if (b >= 'h80 && b < 'hF0) begin
        rs = b; have = 0;
      end else if (b >= 'hF0) begin
        rs = -1; have = 0;
      end else if (rs >= 0) begin
        hi = rs / 16;
        if (hi == 12 || hi == 13) begin
        end else if (have == 0) begin
          d1m = b; have = 1;
        end else begin
          have = 0;
          e.c = rs % 16; e.n = d1m; e.v = b;
          if (hi == 8) begin got = 1'b1; e.t = 0; end
          else if (hi == 9) begin got = 1'b1; e.t = (b != 0) ? 1 : 0; end
          else if (hi == 11) begin got = 1'b1; e.t = 2; end
`ifdef MIDI_CHAN_FILTER_EN
          if (e.c != int'(chan_sel)) got = 1'b0;
`endif
        end
      end
    end
    if (rd && q.size() > 0) void'(q.pop_front());
    if (got) begin
      if (q.size() < DEPTH) q.push_back(e);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("ev_valid", ev_valid, (q.size() != 0));
    if (q.size() != 0) begin
      chk("ev_type", ev_type, q[0].t);
      chk("ev_chan", ev_chan, q[0].c);
      chk("ev_note", ev_note, q[0].n);
      chk("ev_vel",  ev_vel,  q[0].v);
    end
    chk("fifo_full", fifo_full, (q.size() == DEPTH));
    chk("overflow", overflow, ovf_m);
  endtask

  task automatic step(input logic [7:0] b, input bit v, input bit rd);
    @(negedge clk);
    byte_in = b; byte_valid = v; ev_rd = rd;
    model_edge(b, v, rd);
    @(posedge clk);
    #1;
    byte_valid = 1'b0; ev_rd = 1'b0;
    check_model();
  endtask

  task automatic send(input logic [7:0] b);
    step(b, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; byte_valid = 1'b0; ev_rd = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_type", ev_type, 0);
    chk("rst_ev_chan", ev_chan, 0);
    chk("rst_ev_note", ev_note, 0);
    chk("rst_ev_vel", ev_vel, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b; bit v; bit rd;
    bit xvalid; logic [1:0] xt; logic [3:0] xc; logic [6:0] xn; logic [6:0] xvel;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] b, input bit v, input bit rd, input bit xvalid,
                     input logic [1:0] xt, input logic [3:0] xc, input logic [6:0] xn,
                     input logic [6:0] xvel);
    vec_t r;
    r = '{b, v, rd, xvalid, xt, xc, xn, xvel};
    tbl.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    add(8'h90, 1, 0, 0, 0, 0, 0, 0);
    add(8'h3C, 1, 0, 0, 0, 0, 0, 0);
    add(8'h64, 1, 0, 1, 2'b01, 4'h0, 7'h3C, 7'h64);
    add(8'h00, 0, 1, 0, 0, 0, 0, 0);
    add(8'h80, 1, 0, 0, 0, 0, 0, 0);
    add(8'h3C, 1, 0, 0, 0, 0, 0, 0);
    add(8'hF8, 1, 0, 0, 0, 0, 0, 0);
    add(8'h40, 1, 0, 1, 2'b00, 4'h0, 7'h3C, 7'h40);
    add(8'hC5, 1, 1, 0, 0, 0, 0, 0);
    add(8'h10, 1, 0, 0, 0, 0, 0, 0);
    add(8'hF0, 1, 0, 0, 0, 0, 0, 0);
    add(8'h7E, 1, 0, 0, 0, 0, 0, 0);
    add(8'h01, 1, 0, 0, 0, 0, 0, 0);
    add(8'hF7, 1, 0, 0, 0, 0, 0, 0);
    add(8'h3C, 1, 0, 0, 0, 0, 0, 0);
    add(8'h64, 1, 0, 0, 0, 0, 0, 0);
    add(8'hB2, 1, 0, 0, 0, 0, 0, 0);
    add(8'h07, 1, 0, 0, 0, 0, 0, 0);
    add(8'h50, 1, 0, 1, 2'b10, 4'h2, 7'h07, 7'h50);
    add(8'h00, 0, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].v, tbl[i].rd);
      chk("tbl_valid", ev_valid, tbl[i].xvalid);
      if (tbl[i].xvalid) begin
        chk("tbl_type", ev_type, tbl[i].xt);
        chk("tbl_chan", ev_chan, tbl[i].xc);
        chk("tbl_note", ev_note, tbl[i].xn);
        chk("tbl_vel",  ev_vel,  tbl[i].xvel);
      end
    end

    // Running status: note-on then velocity-zero note-off on channel 1.
    send(8'h91); send(8'h40); send(8'h7F);
    send(8'h40); send(8'h00);
    chk("rs_first_type", ev_type, 2'b01);
    chk("rs_first_vel", ev_vel, 7'h7F);
    step(8'h00, 0, 1);
    chk("rs_second_type", ev_type, 2'b00);
    chk("rs_second_chan", ev_chan, 4'h1);
    chk("rs_second_vel", ev_vel, 7'h00);
    step(8'h00, 0, 1);
    chk("rs_empty", ev_valid, 0);

    // Overflow: five note-ons with no reads.
    send(8'h90);
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h30 + i)); send(8'h40);
      if (i == 3) chk("ovf_full_after4", fifo_full, 1);
      if (i == 3) chk("ovf_clear_after4", overflow, 0);
    end
    chk("ovf_set_after5", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_note", ev_note, 7'(8'h30 + i));
      step(8'h00, 0, 1);
    end
    chk("ovf_drained", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Push and pop together while full.
    do_reset();
    send(8'h92);
    for (int i = 0; i < 4; i++) begin send(8'(8'h50 + i)); send(8'h11); end
    send(8'h54);
    step(8'h22, 1, 1);
    chk("pp_full", fifo_full, 1);
    chk("pp_no_ovf", overflow, 0);
    chk("pp_head", ev_note, 7'h51);
    for (int i = 0; i < 4; i++) step(8'h00, 0, 1);
    chk("pp_drained", ev_valid, 0);

    // Reset mid-message discards the partial note-on.
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    chk("rm_no_event", ev_valid, 0);
    send(8'h90); send(8'h3C); send(8'h64);
    chk("rm_event", ev_valid, 1);
    chk("rm_note", ev_note, 7'h3C);
    chk("rm_vel", ev_vel, 7'h64);

    // Randomized byte streams.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      int k;
      if ($urandom_range(0, 499) == 0) do_reset();
      k = $urandom_range(0, 11);
      if (k <= 5)       b = 8'($urandom_range(0, 8'h7F));
      else if (k <= 7)  b = 8'($urandom_range(8'h80, 8'hEF));
      else if (k == 8)  b = 8'hF0;
      else if (k == 9)  b = 8'hF7;
      else if (k == 10) b = 8'($urandom_range(8'hF8, 8'hFF));
      else              b = 8'($urandom_range(8'hF1, 8'hF6));
      step(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
